// File: rtl/router_pkg.sv
// Shared constants and helpers for the router output-channel FIFO.
package router_pkg;

    localparam int ROUTER_DATA_WIDTH = 8;
    localparam int ROUTER_LEN_MSB    = 7;
    localparam int ROUTER_LEN_LSB    = 2;

    // Pointer carries one extra wrap bit beyond the address bits.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array: synchronous write, combinational read.
module router_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware router output FIFO with header tagging and packet-length tracking.
// Define ROUTER_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = ROUTER_DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int LEN_MSB    = ROUTER_LEN_MSB,
    parameter int LEN_LSB    = ROUTER_LEN_LSB
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  soft_rst,
    input  logic                  write_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enb,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic                  empty,
    output logic                  full,
    output logic [$clog2(DEPTH):0] count,
    output logic                  pkt_busy
`ifdef ROUTER_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int ADDR_W = PTR_W - 1;
    localparam int PKT_W  = LEN_MSB - LEN_LSB + 2;

    logic [PTR_W-1:0]    wr_ptr, rd_ptr, count_r;
    logic [PKT_W-1:0]    pkt_cnt;
    logic [DATA_WIDTH:0] rd_word;
    logic                wr_acc, rd_acc, rd_hdr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign wr_acc   = write_enb && !full;
    assign rd_acc   = read_enb && !empty;
    assign rd_hdr   = rd_word[DATA_WIDTH];
    assign count    = count_r;
    assign pkt_busy = (pkt_cnt != '0);

    router_fifo_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata ({lfd_state, data_in}),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rd_word)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else if (soft_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_r <= count_r + PTR_W'(1);
                2'b01:   count_r <= count_r - PTR_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Header length excludes the parity word, hence the +1 on load.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            pkt_cnt   <= '0;
        end else if (soft_rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            out_valid <= rd_acc;
            if (rd_acc) begin
                data_out <= rd_word[DATA_WIDTH-1:0];
                if (rd_hdr)
                    pkt_cnt <= PKT_W'(rd_word[LEN_MSB:LEN_LSB]) + PKT_W'(1);
                else if (pkt_busy)
                    pkt_cnt <= pkt_cnt - PKT_W'(1);
            end else if (!pkt_busy) begin
                data_out <= '0;
            end
        end
    end

`ifdef ROUTER_FIFO_ERR_EN
    // A header arriving before the previous packet drained means truncation.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (soft_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_enb && full) overflow <= 1'b1;
            if ((read_enb && empty) || (rd_acc && rd_hdr && pkt_busy)) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench for router_pkt_fifo: vector table, directed corners, random vs queue model.
module tb_router_pkt_fifo;

    logic       clock, rst, soft_rst, write_enb, lfd_state, read_enb;
    logic [7:0] data_in, data_out;
    logic       out_valid, empty, full, pkt_busy;
    logic [4:0] count;
`ifdef ROUTER_FIFO_ERR_EN
    logic       overflow, underflow;
`endif

    router_pkt_fifo dut (
        .clock(clock), .rst(rst), .soft_rst(soft_rst), .write_enb(write_enb),
        .lfd_state(lfd_state), .data_in(data_in), .read_enb(read_enb),
        .data_out(data_out), .out_valid(out_valid), .empty(empty), .full(full),
        .count(count), .pkt_busy(pkt_busy)
`ifdef ROUTER_FIFO_ERR_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: a queue of {header_flag, data} words plus remaining packet length.
    logic [8:0] m_q[$];
    int         m_rem;
    logic [7:0] m_dout;
    logic       m_valid, m_ov, m_un;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rem = 0; m_dout = 8'h00; m_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    endtask

    task automatic model_edge();
        logic       m_full, m_empty, racc, wacc;
        logic [8:0] w;
        if (soft_rst) begin
            model_reset();
            return;
        end
        m_full  = (m_q.size() == 16);
        m_empty = (m_q.size() == 0);
        wacc = write_enb && !m_full;
        racc = read_enb && !m_empty;
        if (write_enb && m_full) m_ov = 1'b1;
        if (read_enb && m_empty) m_un = 1'b1;
        m_valid = racc;
        if (racc) begin
            w = m_q.pop_front();
            m_dout = w[7:0];
            if (w[8]) begin
                if (m_rem != 0) m_un = 1'b1;
                m_rem = int'(w[7:2]) + 1;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end
        end else if (m_rem == 0) begin
            m_dout = 8'h00;
        end
        if (wacc) m_q.push_back({lfd_state, data_in});
    endtask

    task automatic cmp_model();
        chk("m_count", 32'(count), 32'(m_q.size()));
        chk("m_empty", 32'(empty), 32'(m_q.size() == 0));
        chk("m_full", 32'(full), 32'(m_q.size() == 16));
        chk("m_data_out", 32'(data_out), 32'(m_dout));
        chk("m_out_valid", 32'(out_valid), 32'(m_valid));
        chk("m_pkt_busy", 32'(pkt_busy), 32'(m_rem != 0));
`ifdef ROUTER_FIFO_ERR_EN
        chk("m_overflow", 32'(overflow), 32'(m_ov));
        chk("m_underflow", 32'(underflow), 32'(m_un));
`endif
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        cmp_model();
    endtask

    task automatic drive(input logic we, input logic lfd, input logic [7:0] d, input logic re);
        write_enb = we; lfd_state = lfd; data_in = d; read_enb = re; soft_rst = 1'b0;
        step();
    endtask

    typedef struct {
        logic       we, lfd, re;
        logic [7:0] din;
        logic [4:0] e_count;
        logic       e_empty, e_full, e_valid, e_busy;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vecs[34];

    initial begin
        // Table: header 0x39 + 15 payload words, one dropped write, then drain plus one empty read.
        for (int i = 0; i < 17; i++) begin
            vecs[i].we = 1'b1; vecs[i].lfd = (i == 0); vecs[i].re = 1'b0;
            vecs[i].din = (i == 0) ? 8'h39 : ((i == 16) ? 8'hAA : 8'(4 + i));
            vecs[i].e_count = (i >= 15) ? 5'd16 : 5'(i + 1);
            vecs[i].e_empty = 1'b0; vecs[i].e_full = (i >= 15);
            vecs[i].e_valid = 1'b0; vecs[i].e_busy = 1'b0; vecs[i].e_dout = 8'h00;
        end
        for (int j = 0; j < 17; j++) begin
            vecs[17+j].we = 1'b0; vecs[17+j].lfd = 1'b0; vecs[17+j].re = 1'b1; vecs[17+j].din = 8'h00;
            vecs[17+j].e_count = (j >= 16) ? 5'd0 : 5'(15 - j);
            vecs[17+j].e_empty = (j >= 15); vecs[17+j].e_full = 1'b0;
            vecs[17+j].e_valid = (j < 16); vecs[17+j].e_busy = (j < 15);
            vecs[17+j].e_dout = (j == 0) ? 8'h39 : ((j == 16) ? 8'h00 : 8'(4 + j));
        end

        rst = 1'b1; soft_rst = 1'b0; write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b0; data_in = 8'h00;
        model_reset();
        repeat (3) @(posedge clock);
        #1 rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_pkt_busy", 32'(pkt_busy), 0);

        for (int k = 0; k < 34; k++) begin
            drive(vecs[k].we, vecs[k].lfd, vecs[k].din, vecs[k].re);
            chk($sformatf("vec%0d_count", k), 32'(count), 32'(vecs[k].e_count));
            chk($sformatf("vec%0d_empty", k), 32'(empty), 32'(vecs[k].e_empty));
            chk($sformatf("vec%0d_full", k), 32'(full), 32'(vecs[k].e_full));
            chk($sformatf("vec%0d_data_out", k), 32'(data_out), 32'(vecs[k].e_dout));
            chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(vecs[k].e_valid));
            chk($sformatf("vec%0d_pkt_busy", k), 32'(pkt_busy), 32'(vecs[k].e_busy));
        end

        // Simultaneous read/write when full: write dropped.
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        drive(1'b1, 1'b0, 8'hEE, 1'b1);
        chk("rw_full_count", 32'(count), 15);
        chk("rw_full_data", 32'(data_out), 32'h80);
        for (int i = 0; i < 15; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        // Simultaneous read/write when empty: read dropped.
        drive(1'b1, 1'b0, 8'h5A, 1'b1);
        chk("rw_empty_count", 32'(count), 1);
        chk("rw_empty_valid", 32'(out_valid), 0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("rw_empty_data", 32'(data_out), 32'h5A);

        // Pointer wrap: fill 10, drain 10, then 20 concurrent write/read cycles.
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'(8'hC0 + i), 1'b1);
        chk("wrap_count", 32'(count), 1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("wrap_last", 32'(data_out), 32'hD3);

        // soft_rst mid-packet with concurrent read/write requests.
        drive(1'b1, 1'b1, 8'h20, 1'b0);
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("srst_pre_count", 32'(count), 7);
        chk("srst_pre_busy", 32'(pkt_busy), 1);
        write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h77; lfd_state = 1'b0; soft_rst = 1'b1;
        step();
        chk("srst_count", 32'(count), 0);
        chk("srst_empty", 32'(empty), 1);
        chk("srst_busy", 32'(pkt_busy), 0);
        chk("srst_data", 32'(data_out), 0);

        // Asynchronous reset mid-packet, mid-cycle.
        drive(1'b1, 1'b1, 8'h10, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        write_enb = 1'b0; read_enb = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_data", 32'(data_out), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_busy", 32'(pkt_busy), 0);
        model_reset();
        #2 rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);

`ifdef ROUTER_FIFO_ERR_EN
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
        drive(1'b1, 1'b0, 8'hFF, 1'b0);
        chk("err_ovf", 32'(overflow), 1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("err_ovf_hold", 32'(overflow), 1);
        for (int i = 0; i < 17; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("err_unf", 32'(underflow), 1);
        write_enb = 1'b0; read_enb = 1'b0; soft_rst = 1'b1;
        step();
        chk("err_clr_ovf", 32'(overflow), 0);
        chk("err_clr_unf", 32'(underflow), 0);
`endif

        // Random traffic in phases with varying write/read bias.
        for (int ph = 0; ph < 6; ph++) begin
            int pw, pr;
            pw = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 30 : 55);
            pr = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 80 : 55);
            for (int c = 0; c < 100; c++) begin
                write_enb = ($urandom_range(0, 99) < pw);
                read_enb  = ($urandom_range(0, 99) < pr);
                lfd_state = ($urandom_range(0, 7) == 0);
                data_in   = 8'($urandom);
                soft_rst  = ($urandom_range(0, 63) == 0);
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/router_pkt_fifo.md
# router_pkt_fifo

Parametrised, packet-aware synchronous FIFO for the router output channels. It buffers header/payload/parity bytes written by the router FSM and tags each word with a header flag. On read it tracks the remaining packet length decoded from the header and reports occupancy. One instance per output port; it generalises the fixed 8-bit/16-deep channel FIFO.

## Interface
- DATA_WIDTH, 8, payload word width (≥ 4)
- DEPTH, 16, number of entries; power of two, ≥ 4
- LEN_MSB, 7, MSB of the length field in the header word
- LEN_LSB, 2, LSB of the length field in the header word
- clock  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- soft_rst  in  1  synchronous, active-high flush
- write_enb  in  1  write request
- lfd_state  in  1  current write word is a header
- data_in  in  DATA_WIDTH  write data
- read_enb  in  1  read request
- data_out  out  DATA_WIDTH  registered read data
- out_valid  out  1  data_out updated this cycle
- empty  out  1  no stored words
- full  out  1  DEPTH words stored
- count  out  $clog2(DEPTH)+1  occupancy
- pkt_busy  out  1  packet read in progress (remaining length ≠ 0)

## Operation
- Storage: DEPTH × (DATA_WIDTH+1); bit DATA_WIDTH holds the header flag (lfd_state sampled at write).
- Pointers: ADDR_W+1 bits (ADDR_W = $clog2(DEPTH)), wrapping naturally. Empty = pointers equal. Full = MSBs differ and lower bits equal.
- Write accepted iff write_enb && !full. Read accepted iff read_enb && !empty. Both flags are evaluated on registered state.
- Simultaneous accepted read and write: count unchanged.
- When full: a simultaneous read is accepted and the write is rejected.
- When empty: a simultaneous write is accepted and the read is rejected.
- Rejected requests are dropped silently; pointers, count and memory are unchanged.
- Packet counter `pkt_cnt`: LEN_MSB-LEN_LSB+2 bits wide.
  - Accepted read of a header-flagged word: load header[LEN_MSB:LEN_LSB]+1, covering payload plus parity.
  - Any other accepted read with pkt_cnt ≠ 0: decrement.
  - pkt_busy = (pkt_cnt ≠ 0).
- data_out:
  - Accepted read: loads the stored word.
  - Otherwise, if pkt_busy = 0: cleared to 0. This replaces the earlier tri-state output.
  - Otherwise: holds its value.
- soft_rst: clears pointers, count, pkt_cnt, data_out and out_valid on the next edge. Memory contents are not cleared. soft_rst has priority over simultaneous read and write.
- Reset (rst) values: data_out=0, out_valid=0, empty=1, full=0, count=0, pkt_busy=0, pointers=0. Memory is not reset.
- Reset asserted mid-packet aborts immediately; outputs take reset values asynchronously.

## Timing
- Read latency: 1 cycle. A read accepted at edge N gives data_out/out_valid valid after edge N.
- empty deasserts after the edge that accepts the first write.
- full asserts after the edge that accepts the DEPTH-th outstanding write.
- count, empty and full are registered and consistent in every cycle.
- out_valid is a single-cycle pulse per accepted read.
- pkt_busy rises the cycle after the header read and falls the cycle after the parity word is read.

## Configuration
- ROUTER_FIFO_ERR_EN
  - Defined: adds outputs `overflow` and `underflow` (1 bit each, sticky).
    - `overflow` sets on write_enb && full.
    - `underflow` sets on read_enb && empty.
    - Both are cleared by rst or soft_rst.
    - A header read while pkt_busy=1 also sets `underflow`, flagging a truncated packet.
  - Undefined: ports absent; no error logic.

## Structure
- Package `router_pkg`:
  - default DATA_WIDTH
  - LEN_MSB/LEN_LSB constants
  - function computing the pointer width from DEPTH
- Sub-module `router_fifo_mem`: simple dual-port register array with write enable and combinational read address. Flag and pointer logic stay in the top module.

## Test plan
All scenarios use the defaults (DATA_WIDTH=8, DEPTH=16).

- Reset, then write header 0x39 (lfd_state=1) plus 15 words 0x05–0x13 → full=1 and count=16 after the 16th edge; a 17th write is dropped (count stays 16).
- Read 16 words → data_out sequence 0x39, 0x05…0x13, one per cycle after each accepted read. pkt_busy rises after the header (length 14+1=15) and falls after the 16th read. empty=1 and data_out=0 afterwards.
- Simultaneous read/write at count=16 → read accepted, write dropped, count=15. The same at count=0 → write accepted, count=1, out_valid=0.
- Fill 10 words, drain 10, then write/read 20 more → correct data order across pointer wrap; count never exceeds 16.
- soft_rst=1 mid-packet (pkt_busy=1, count=7) → next cycle count=0, empty=1, pkt_busy=0, data_out=0. rst asserted mid-cycle clears the outputs without a clock edge.
- With ROUTER_FIFO_ERR_EN: write when full → overflow=1 and held; read when empty → underflow=1; soft_rst clears both.
